// File: rtl/gen_scope_pkg.sv
// Shared types and constants for the nested-generate-scope reader and its shadow model.
package gen_scope_pkg;

  typedef enum logic [2:0] {
    GS_IDLE,
    GS_LOAD,
    GS_RUN,
    GS_LAST,
    GS_DONE
  } gs_state_t;

  localparam logic [1:0] GS_Z_INIT   = 2'b01;
  localparam logic [1:0] GS_XOR_MASK = 2'b11;
  localparam logic [3:0] GS_FAIL_MAX = 4'hF;

  // Swap the two bits of a 2-bit value (a 2-bit rotate in either direction).
  function automatic logic [1:0] gs_rotate(input logic [1:0] v);
    return {v[0], v[1]};
  endfunction

endpackage

// File: rtl/gen_scope_model.sv
// Shadow model of the scoped registers: tracks y and z independently and produces
// the value A.x is expected to hold, with optional bit-0 fault injection.
module gen_scope_model
  import gen_scope_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step_en,
  input  logic [1:0] seed,
  input  logic       inj,
  output logic [1:0] exp
);

  logic [1:0] sy_q, sy_d;
  logic [1:0] sz_q, sz_d;
  logic [1:0] exp_q, exp_d;

  // Next shadow state: seed on load, advance y/z and form the expected x on each step.
  always_comb begin
    sy_d  = sy_q;
    sz_d  = sz_q;
    exp_d = exp_q;
    if (load) begin
      sy_d = seed;
      sz_d = GS_Z_INIT;
    end else if (step_en) begin
      exp_d = sy_q ^ GS_XOR_MASK ^ sz_q ^ {1'b0, inj};
      sy_d  = sy_q + 2'd1;
      sz_d  = gs_rotate(sz_q);
    end
  end

  // Shadow registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sy_q  <= '0;
      sz_q  <= '0;
      exp_q <= '0;
    end else begin
      sy_q  <= sy_d;
      sz_q  <= sz_d;
      exp_q <= exp_d;
    end
  end

  assign exp = exp_q;

endmodule

// File: rtl/gen_scope_reader.sv
// Checker that drives registers living in nested named generate scopes (A, A.B, A.C)
// through relative, scope-qualified and module-qualified names, and compares A.x
// against an independent shadow model for N_STEPS cycles per run.
module gen_scope_reader
  import gen_scope_pkg::*;
#(
  parameter int N_STEPS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] seed,
  input  logic       inj,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_count,
  output logic [1:0] x_out
);

  localparam logic [7:0] LAST_STEP = 8'(N_STEPS - 1);

  gs_state_t  state_q, state_d;
  logic [7:0] step_q, step_d;
  logic [3:0] fail_count_q, fail_count_d;
  logic       pass_q, pass_d;

  logic [1:0] x_d, y_d, z_d;
  logic       model_load, model_step, cmp_en;
  logic [1:0] exp_val;

  // The scopes under test; their registers are written only from the top level.
  if (1'b1) begin : A
    logic [1:0] x;
    logic [1:0] y_view;
    if (1'b1) begin : B
      logic [1:0] y;
    end
    if (1'b1) begin : C
      logic [1:0] z;
    end
    assign y_view = B.y;
  end

  gen_scope_model u_model (
    .clk     (clk),
    .rst     (rst),
    .load    (model_load),
    .step_en (model_step),
    .seed    (seed),
    .inj     (inj),
    .exp     (exp_val)
  );

  // Next-state, scoped-register updates and saturating mismatch counting.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    fail_count_d = fail_count_q;
    pass_d       = pass_q;
    x_d          = gen_scope_reader.A.x;
    y_d          = A.y_view;
    z_d          = A.C.z;
    model_load   = 1'b0;
    model_step   = 1'b0;
    cmp_en       = 1'b0;
    case (state_q)
      GS_IDLE: begin
        if (start) state_d = GS_LOAD;
      end
      GS_LOAD: begin
        y_d          = seed;
        z_d          = GS_Z_INIT;
        step_d       = '0;
        fail_count_d = '0;
        pass_d       = 1'b0;
        model_load   = 1'b1;
        state_d      = GS_RUN;
      end
      GS_RUN: begin
        x_d        = A.y_view ^ GS_XOR_MASK ^ A.C.z;
        y_d        = A.y_view + 2'd1;
        z_d        = gs_rotate(A.C.z);
        model_step = 1'b1;
        cmp_en     = (step_q != 8'd0);
        if (step_q == LAST_STEP) state_d = GS_LAST;
        else                     step_d  = step_q + 8'd1;
      end
      GS_LAST: begin
        cmp_en  = 1'b1;
        state_d = GS_DONE;
      end
      GS_DONE: begin
        pass_d  = (fail_count_q == 4'd0);
        state_d = GS_IDLE;
      end
      default: state_d = GS_IDLE;
    endcase
    if (cmp_en && (gen_scope_reader.A.x != exp_val) && (fail_count_q != GS_FAIL_MAX))
      fail_count_d = fail_count_q + 4'd1;
  end

  // State, counters and the scoped registers, all cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                <= GS_IDLE;
      step_q                 <= '0;
      fail_count_q           <= '0;
      pass_q                 <= 1'b0;
      gen_scope_reader.A.x   <= '0;
      gen_scope_reader.A.B.y <= '0;
      gen_scope_reader.A.C.z <= '0;
    end else begin
      state_q                <= state_d;
      step_q                 <= step_d;
      fail_count_q           <= fail_count_d;
      pass_q                 <= pass_d;
      gen_scope_reader.A.x   <= x_d;
      gen_scope_reader.A.B.y <= y_d;
      gen_scope_reader.A.C.z <= z_d;
    end
  end

  assign busy       = (state_q == GS_LOAD) || (state_q == GS_RUN) || (state_q == GS_LAST);
  assign done       = (state_q == GS_DONE);
  assign pass       = pass_q;
  assign fail_count = fail_count_q;
  assign x_out      = gen_scope_reader.A.x;

endmodule

// File: tb/tb_gen_scope_reader.sv
// Randomized self-checking bench for gen_scope_reader; four instances cover
// N_STEPS of 8, 4, 20 and 1, checked against a cycle-indexed reference model.
module tb_gen_scope_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [3:0] startV;
   logic [1:0] seedV [4];
   logic [3:0] injV;
   wire  [3:0] busyV;
   wire  [3:0] doneV;
   wire  [3:0] passV;
   wire  [3:0] failV [4];
   wire  [1:0] xV    [4];

   int nOf [4] = '{8, 4, 20, 1};
   int compareCount  = 0;
   int mismatchCount = 0;

   gen_scope_reader #(.N_STEPS(8)) dut8 (
      .clk(clk), .rst(rst), .start(startV[0]), .seed(seedV[0]), .inj(injV[0]),
      .busy(busyV[0]), .done(doneV[0]), .pass(passV[0]), .fail_count(failV[0]), .x_out(xV[0]));
   gen_scope_reader #(.N_STEPS(4)) dut4 (
      .clk(clk), .rst(rst), .start(startV[1]), .seed(seedV[1]), .inj(injV[1]),
      .busy(busyV[1]), .done(doneV[1]), .pass(passV[1]), .fail_count(failV[1]), .x_out(xV[1]));
   gen_scope_reader #(.N_STEPS(20)) dut20 (
      .clk(clk), .rst(rst), .start(startV[2]), .seed(seedV[2]), .inj(injV[2]),
      .busy(busyV[2]), .done(doneV[2]), .pass(passV[2]), .fail_count(failV[2]), .x_out(xV[2]));
   gen_scope_reader #(.N_STEPS(1)) dut1 (
      .clk(clk), .rst(rst), .start(startV[3]), .seed(seedV[3]), .inj(injV[3]),
      .busy(busyV[3]), .done(doneV[3]), .pass(passV[3]), .fail_count(failV[3]), .x_out(xV[3]));

   // Counts one comparison and reports it when observed and expected differ.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      compareCount++;
      if (observed != expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
      end
   endtask

   // Expected A.x after step k: y has advanced k times from the seed and z alternates 01/10.
   function automatic int modelX(input int sd, input int k);
      int y;
      int z;
      y = (sd + k) % 4;
      z = (k % 2 == 0) ? 1 : 2;
      return y ^ 3 ^ z;
   endfunction

   // Runs one check on instance idx from the start edge through the first IDLE cycle,
   // driving inj per RUN step from injMask and checking every output each cycle.
   task automatic applyStimulus(input string lbl, input int idx, input int sd,
                                input logic [31:0] injMask, input bit holdStart);
      int n;
      int ones;
      int expFail;
      int k;
      n = nOf[idx];
      ones = 0;
      for (int i = 0; i < n; i++) if (injMask[i]) ones++;
      expFail = (ones > 15) ? 15 : ones;
      seedV[idx]  = 2'(sd);
      startV[idx] = 1'b1;
      for (int c = 1; c <= n + 4; c++) begin
         @(posedge clk);
         #1;
         if (!holdStart) startV[idx] = 1'b0;
         checkOutput({lbl, ".busy"}, int'(busyV[idx]), (c <= n + 2) ? 1 : 0);
         checkOutput({lbl, ".done"}, int'(doneV[idx]), (c == n + 3) ? 1 : 0);
         if (c >= 3) begin
            k = (c - 3 < n) ? c - 3 : n - 1;
            checkOutput({lbl, ".x_out"}, int'(xV[idx]), modelX(sd, k));
         end
         if (c >= 2 && c <= n + 3) checkOutput({lbl, ".pass_low"}, int'(passV[idx]), 0);
         if (c == n + 4) checkOutput({lbl, ".pass"}, int'(passV[idx]), (expFail == 0) ? 1 : 0);
         if (c == 2) checkOutput({lbl, ".fail_clr"}, int'(failV[idx]), 0);
         if (c >= n + 3) checkOutput({lbl, ".fail_count"}, int'(failV[idx]), expFail);
         injV[idx] = (c >= 2 && c <= n + 1) ? injMask[c - 2] : 1'b0;
      end
   endtask

   // Aborts a run with reset during cycle 5, then confirms a quiet, pulse-free aftermath.
   task automatic resetMidRun();
      seedV[0]  = 2'($urandom_range(0, 3));
      startV[0] = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk);
         #1;
         startV[0] = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rstmid.busy", int'(busyV[0]), 0);
      checkOutput("rstmid.done", int'(doneV[0]), 0);
      checkOutput("rstmid.pass", int'(passV[0]), 0);
      checkOutput("rstmid.fail_count", int'(failV[0]), 0);
      checkOutput("rstmid.x_out", int'(xV[0]), 0);
      rst = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(posedge clk);
         #1;
         checkOutput("rstmid.no_done", int'(doneV[0]), 0);
      end
   endtask

   initial begin
      rst    = 1'b1;
      startV = '0;
      injV   = '0;
      for (int i = 0; i < 4; i++) seedV[i] = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         checkOutput("reset.busy", int'(busyV[i]), 0);
         checkOutput("reset.done", int'(doneV[i]), 0);
         checkOutput("reset.pass", int'(passV[i]), 0);
         checkOutput("reset.fail_count", int'(failV[i]), 0);
         checkOutput("reset.x_out", int'(xV[i]), 0);
      end
      rst = 1'b0;

      applyStimulus("seed0_n8", 0, 0, 32'h0, 1'b0);
      applyStimulus("seed3_n4", 1, 3, 32'h0, 1'b0);
      applyStimulus("inj3_n8", 0, 1, 32'h0000_002C, 1'b0);
      applyStimulus("sat_n20", 2, 2, 32'hFFFF_FFFF, 1'b0);

      resetMidRun();
      applyStimulus("after_rst", 0, int'($urandom_range(0, 3)), 32'h0, 1'b0);

      for (int r = 0; r < 3; r++)
         applyStimulus("b2b_n1", 3, int'($urandom_range(0, 3)), 32'h0, 1'b1);
      startV[3] = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         checkOutput("b2b_n1.idle", int'(busyV[3]), 0);
      end

      for (int r = 0; r < 12; r++) begin
         int idx;
         logic [31:0] mask;
         idx  = int'($urandom_range(0, 3));
         mask = (r % 4 == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
         applyStimulus("rand", idx, int'($urandom_range(0, 3)), mask, 1'b0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/gen_scope_reader.md
# gen_scope_reader

Sequential companion to the nested-generate-scope tests in the frontend regression suite. Nested named generate blocks `A`, `A.B` and `A.C` hold registers that the top level writes and reads through hierarchical names (relative, scope-qualified and module-qualified). A top-level checker FSM drives the scoped registers for N steps. It compares `A.x` against an independent shadow model and reports pass/fail, so frontend scope-resolution errors show up as a simulation or equivalence mismatch.

## Interface
- `N_STEPS`, default 8: RUN cycles per check; legal range 1..255.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begins a check run; sampled only in IDLE.
- `seed`, input, 2: initial value loaded into `A.B.y`.
- `inj`, input, 1: fault injection; inverts bit 0 of the shadow expected value in any RUN cycle where it is high.
- `busy`, output, 1: high in LOAD, RUN and LAST.
- `done`, output, 1: one-cycle pulse in DONE.
- `pass`, output, 1: registered; set in DONE when `fail_count==0`; held until the next LOAD.
- `fail_count`, output, 4: mismatches in the current run; saturates at 15.
- `x_out`, output, 2: continuous copy of `A.x`.

## Operation
- Scopes:
  - `A`: reg `x[1:0]`.
  - `A.B`: reg `y[1:0]`.
  - `A.C`: reg `z[1:0]`.
  - Top-level writes use the module-qualified form `gen_scope_reader.A.B.y`. Reads use every form: `B.y` inside `A`; `A.C.z` and `gen_scope_reader.A.x` at top.
- FSM states: IDLE, LOAD, RUN, LAST, DONE.
  - IDLE: `start` moves to LOAD. `start` in any other state is ignored.
  - LOAD: `y<=seed`, `z<=2'b01`, shadow `sy<=seed`, `sz<=2'b01`, `step<=0`, `fail_count<=0`, `pass<=0`. Moves to RUN.
  - RUN, step k:
    - `x <= y ^ 2'b11 ^ z` (pre-update values).
    - `y <= y+1`, wrapping mod 4.
    - `z <= {z[0],z[1]}` (rotate).
    - Shadow: `exp <= sy ^ 2'b11 ^ sz ^ {1'b0,inj}`, with `sy` and `sz` updated identically to `y` and `z`.
    - If k≥1, compare `A.x` with `exp`; a mismatch increments `fail_count`, saturating.
    - When k==N_STEPS-1, move to LAST; otherwise `step++`.
  - LAST: final compare of `A.x` with `exp`. Moves to DONE.
  - DONE: `done=1`, `pass<=(fail_count==0)`. Moves to IDLE.
- Arithmetic is 2-bit throughout and wraps; no width extension. `fail_count` is 4-bit saturating.
- Reset value of every register and output is 0: `x`, `y`, `z`, `sy`, `sz`, `exp`, `step`, `fail_count`, `pass`, `done`, `busy`, `x_out`. State is IDLE.
- Reset during any state aborts the run at the next edge; no `done` pulse is produced.

## Timing
- With `start` sampled at edge 0:
  - LOAD at cycle 1.
  - RUN at cycles 2..N_STEPS+1.
  - LAST at cycle N_STEPS+2.
  - DONE at cycle N_STEPS+3.
  - IDLE from cycle N_STEPS+4.
- `x_out` reflects RUN step k one cycle later.
- `busy` falls in the DONE cycle. `pass` is valid from the cycle after DONE.
- `start` asserted in the DONE cycle is ignored. `start` asserted in the first IDLE cycle after DONE is accepted (back-to-back runs).
- `inj` takes effect on the compare one cycle after the RUN cycle in which it is sampled.

## Structure
- Shared package `gen_scope_pkg` holds:
  - state enum `gs_state_t`;
  - `GS_Z_INIT = 2'b01`;
  - `GS_XOR_MASK = 2'b11`.
- One sub-module, `gen_scope_model`: the shadow model (`sy`, `sz`, `exp`) with inputs `clk`, `rst`, `load`, `step_en`, `seed`, `inj`.
- The generate scopes and the FSM stay in the top module, because the scopes under test must live there.

## Test plan
- Reset, then `start` with `seed=0`, `N_STEPS=8`, `inj=0`:
  - `x_out` follows 2,0,0,2,2,0,0,2;
  - `done` is high at cycle 11;
  - `pass=1`, `fail_count=0`.
- `seed=3`, `N_STEPS=4`: `x_out` follows 1,1,3,3; `pass=1`.
- `inj` high for exactly 3 RUN cycles: `fail_count=3`, `pass=0`.
- `inj` held high for a full run with `N_STEPS=20`: `fail_count` saturates at 15; `pass=0`.
- `rst` pulsed at cycle 5 of a run:
  - all outputs are 0 the next cycle and no `done` pulse occurs;
  - a fresh `start` then completes with `pass=1`.
- `start` held high continuously with `N_STEPS=1`:
  - `start` is ignored while busy and in DONE;
  - back-to-back runs of 5 cycles each (LOAD, RUN, LAST, DONE, IDLE), each with `pass=1`.
